// File: rtl/correlation_pkg.sv
// correlation_pkg: default geometry and pixel/product types shared by the correlation line.
package correlation_pkg;
  localparam int PIXEL_SIZE = 8;
  localparam int LINE_SIZE = 10;
  localparam int NUM_TEMPLATES = 10;
  typedef logic [PIXEL_SIZE-1:0] pixel_t;
  typedef logic [2*PIXEL_SIZE-1:0] prod_t;
endpackage

// File: rtl/correlation_cell.sv
// correlation_cell: one column registering I, I^2 and T*I for every template.
// CORRELATION_LINE_PIPE2_EN adds a second register stage behind the multipliers.
module correlation_cell #(
  parameter int PIXEL_SIZE = correlation_pkg::PIXEL_SIZE,
  parameter int NUM_TEMPLATES = correlation_pkg::NUM_TEMPLATES
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic [PIXEL_SIZE-1:0]                        i_pix,
  input  logic [NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0]     t_vec,
  output logic [2*PIXEL_SIZE-1:0]                      i_out,
  output logic [2*PIXEL_SIZE-1:0]                      i_sq,
  output logic [NUM_TEMPLATES-1:0][2*PIXEL_SIZE-1:0]   t_x_i
);
  localparam int W = 2*PIXEL_SIZE;
  logic [W-1:0] i_d, i_q, sq_d, sq_q;
  logic [NUM_TEMPLATES-1:0][W-1:0] txi_d, txi_q;
  always_comb begin
    i_d = {{PIXEL_SIZE{1'b0}}, i_pix};
    sq_d = W'(i_pix) * W'(i_pix);
    for (int k = 0; k < NUM_TEMPLATES; k++) txi_d[k] = W'(t_vec[k]) * W'(i_pix);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_q <= '0;
      sq_q <= '0;
      txi_q <= '0;
    end else begin
      i_q <= i_d;
      sq_q <= sq_d;
      txi_q <= txi_d;
    end
  end
`ifdef CORRELATION_LINE_PIPE2_EN
  logic [W-1:0] i2_d, i2_q, sq2_d, sq2_q;
  logic [NUM_TEMPLATES-1:0][W-1:0] txi2_d, txi2_q;
  always_comb begin
    i2_d = i_q;
    sq2_d = sq_q;
    txi2_d = txi_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i2_q <= '0;
      sq2_q <= '0;
      txi2_q <= '0;
    end else begin
      i2_q <= i2_d;
      sq2_q <= sq2_d;
      txi2_q <= txi2_d;
    end
  end
  assign i_out = i2_q;
  assign i_sq = sq2_q;
  assign t_x_i = txi2_q;
`else
  assign i_out = i_q;
  assign i_sq = sq_q;
  assign t_x_i = txi_q;
`endif
endmodule

// File: rtl/correlation_line_core.sv
// correlation_line_core: LINE_SIZE correlation cells with T*I regrouped per template.
// CORRELATION_LINE_PIPE2_EN (in correlation_cell) makes the latency 2 clocks.
module correlation_line_core #(
  parameter int PIXEL_SIZE = correlation_pkg::PIXEL_SIZE,
  parameter int LINE_SIZE = correlation_pkg::LINE_SIZE,
  parameter int NUM_TEMPLATES = correlation_pkg::NUM_TEMPLATES
) (
  input  logic                                                       CLK,
  input  logic                                                       RST,
  input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                       I_in_line,
  input  logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0]    T_in_line,
  output logic [LINE_SIZE-1:0][2*PIXEL_SIZE-1:0]                     I_square_out_line,
  output logic [LINE_SIZE-1:0][2*PIXEL_SIZE-1:0]                     I_out_line,
  output logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][2*PIXEL_SIZE-1:0]  T_x_I_out_lines_transpose
);
  logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][2*PIXEL_SIZE-1:0] t_x_i;
  for (genvar c = 0; c < LINE_SIZE; c++) begin : g_cell
    correlation_cell #(
      .PIXEL_SIZE(PIXEL_SIZE),
      .NUM_TEMPLATES(NUM_TEMPLATES)
    ) u_cell (
      .CLK(CLK),
      .RST(RST),
      .i_pix(I_in_line[c]),
      .t_vec(T_in_line[c]),
      .i_out(I_out_line[c]),
      .i_sq(I_square_out_line[c]),
      .t_x_i(t_x_i[c])
    );
    for (genvar k = 0; k < NUM_TEMPLATES; k++) begin : g_tr
      assign T_x_I_out_lines_transpose[k][c] = t_x_i[c][k];
    end
  end
endmodule

// File: tb/tb_correlation_line_core.sv
// tb_correlation_line_core: scoreboard bench for correlation_line_core.
module tb_correlation_line_core;
  localparam int PS = 8, L = 10, NT = 10, W = 16;
`ifdef CORRELATION_LINE_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef logic [L-1:0][PS-1:0] iv_t;
  typedef logic [L-1:0][NT-1:0][PS-1:0] tv_t;
  typedef logic [L-1:0][W-1:0] ov_t;
  typedef logic [NT-1:0][L-1:0][W-1:0] txo_t;
  typedef struct {
    int due;
    ov_t i;
    ov_t sq;
    txo_t txi;
    logic [63:0] nm;
  } exp_t;

  logic CLK = 0, RST = 1;
  iv_t I_in_line;
  tv_t T_in_line;
  ov_t I_square_out_line, I_out_line;
  txo_t T_x_I_out_lines_transpose;
  int cyc = 0, n_cmp = 0, n_err = 0;
  exp_t sb[$];
  exp_t e;

  correlation_line_core dut (
    .CLK(CLK),
    .RST(RST),
    .I_in_line(I_in_line),
    .T_in_line(T_in_line),
    .I_square_out_line(I_square_out_line),
    .I_out_line(I_out_line),
    .T_x_I_out_lines_transpose(T_x_I_out_lines_transpose)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.due != cyc) begin
        n_err++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.nm, cyc, e.due);
      end else if (I_out_line != e.i || I_square_out_line != e.sq || T_x_I_out_lines_transpose != e.txi) begin
        n_err++;
        $display("FAIL %s: I_out got %h want %h", e.nm, I_out_line, e.i);
        $display("     %s: I_sq got %h want %h", e.nm, I_square_out_line, e.sq);
        for (int k = 0; k < NT; k++)
          for (int c = 0; c < L; c++)
            if (T_x_I_out_lines_transpose[k][c] != e.txi[k][c])
              $display("     %s: TxI[%0d][%0d] got %0d want %0d", e.nm, k, c, T_x_I_out_lines_transpose[k][c], e.txi[k][c]);
      end
    end
  end

  task automatic drive(input iv_t iv, input tv_t tv, input ov_t ei, input ov_t esq, input txo_t etx, input logic [63:0] nm);
    I_in_line = iv;
    T_in_line = tv;
    sb.push_back('{cyc + LAT, ei, esq, etx, nm});
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_model(input iv_t iv, input tv_t tv, input logic [63:0] nm);
    ov_t ei, esq;
    txo_t etx;
    for (int c = 0; c < L; c++) begin
      ei[c] = W'(iv[c]);
      esq[c] = W'(iv[c]) * W'(iv[c]);
      for (int k = 0; k < NT; k++) etx[k][c] = W'(tv[c][k]) * W'(iv[c]);
    end
    drive(iv, tv, ei, esq, etx, nm);
  endtask

  task automatic chk_zero(input logic [63:0] nm);
    n_cmp++;
    if (I_out_line != '0 || I_square_out_line != '0 || T_x_I_out_lines_transpose != '0) begin
      n_err++;
      $display("FAIL %s: outputs not zero, I_out %h I_sq %h TxI[0] %h", nm, I_out_line, I_square_out_line, T_x_I_out_lines_transpose[0]);
    end
  endtask

  task automatic rand_vec(output iv_t iv, output tv_t tv);
    for (int c = 0; c < L; c++) begin
      iv[c] = PS'($urandom);
      for (int k = 0; k < NT; k++) tv[c][k] = PS'($urandom);
    end
  endtask

  initial begin
    iv_t iv;
    tv_t tv;
    ov_t ei, esq;
    txo_t etx;
    rand_vec(iv, tv);
    I_in_line = iv;
    T_in_line = tv;
    RST = 1;
    #1;
    chk_zero("rst_asyn");
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("rst_hold");
    #3 RST = 0;
    for (int c = 0; c < L; c++) begin
      iv[c] = PS'(c + 1);
      ei[c] = W'(c + 1);
      esq[c] = W'((c + 1) * (c + 1));
      for (int k = 0; k < NT; k++) begin
        tv[c][k] = PS'(k + 1);
        etx[k][c] = W'((k + 1) * (c + 1));
      end
    end
    drive(iv, tv, ei, esq, etx, "basic");
    drive({L{8'd255}}, {L*NT{8'd255}}, {L{16'd255}}, {L{16'd65025}}, {NT*L{16'd65025}}, "all_ff");
    drive('0, '0, '0, '0, '0, "all_zero");
    iv = '0;
    tv = '0;
    ei = '0;
    esq = '0;
    etx = '0;
    iv[3] = 8'd2;
    tv[3][7] = 8'd200;
    ei[3] = 16'd2;
    esq[3] = 16'd4;
    etx[7][3] = 16'd400;
    drive(iv, tv, ei, esq, etx, "transp");
    drive({L{8'd255}}, {L*NT{8'd255}}, {L{16'd255}}, {L{16'd65025}}, {NT*L{16'd65025}}, "ff_again");
    for (int n = 0; n < 20; n++) begin
      rand_vec(iv, tv);
      drive_model(iv, tv, "stream");
    end
    rand_vec(iv, tv);
    I_in_line = iv;
    T_in_line = tv;
    #1 RST = 1;
    sb.delete();
    #1;
    chk_zero("rst_mid");
    @(posedge CLK);
    #1;
    chk_zero("rst_mid2");
    #2 RST = 0;
    for (int n = 0; n < 6; n++) begin
      rand_vec(iv, tv);
      drive_model(iv, tv, "recover");
    end
    repeat (LAT + 1) @(posedge CLK);
    @(negedge CLK);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/correlation_line_core.md
Name: correlation_line_core

Overview:
- One line of template-matching correlation cells: LINE_SIZE cells in parallel, one per pixel column.
- Each cell registers three results per clock:
  - the image pixel, zero-extended;
  - the pixel squared;
  - the pixel times each of NUM_TEMPLATES template pixels.
- Feeds the downstream row/window accumulators (sum I, sum I², sum T·I) of the normalized cross-correlation datapath.
- Template products leave transposed: grouped per template rather than per pixel.

Parameters:
- PIXEL_SIZE, 8, bits per unsigned image/template pixel.
- LINE_SIZE, 10, number of pixel columns (cells) in the line.
- NUM_TEMPLATES, 10, number of templates correlated in parallel.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- I_in_line  input  [LINE_SIZE] x PIXEL_SIZE  image pixels of the current line.
- T_in_line  input  [LINE_SIZE][NUM_TEMPLATES] x PIXEL_SIZE  template pixels, indexed [column][template].
- I_square_out_line  output  [LINE_SIZE] x 2*PIXEL_SIZE  registered I².
- I_out_line  output  [LINE_SIZE] x 2*PIXEL_SIZE  registered I, zero-extended.
- T_x_I_out_lines_transpose  output  [NUM_TEMPLATES][LINE_SIZE] x 2*PIXEL_SIZE  registered T·I, indexed [template][column].

Behaviour:
- Reset:
  - RST high asynchronously clears every output element to 0, with no clock needed.
  - Outputs stay 0 while RST is held.
  - First capture happens on the first rising CLK edge after RST deasserts.
- Per cell c, at each rising CLK edge with RST low:
  - I_out_line[c] <= {PIXEL_SIZE'b0, I_in_line[c]}.
  - I_square_out_line[c] <= I_in_line[c] * I_in_line[c].
  - for every k: T_x_I_out_lines_transpose[k][c] <= T_in_line[c][k] * I_in_line[c].
- Arithmetic:
  - Unsigned multiply, full 2*PIXEL_SIZE result. No overflow is possible: max is 255*255 = 65025 < 65536.
  - No rounding, no saturation.
- Latency and flow:
  - 1 clock from input to output (default build).
  - Fully pipelined: new data accepted every cycle, no handshake, no stall.
  - Outputs hold their value until the next edge.
- Transpose: pure wiring. Cell c drives column c of every template row; no extra logic or delay.
- Boundaries:
  - All-zero inputs give all-zero outputs.
  - All-255 inputs give 65025 on every product.
  - RST asserted mid-stream discards in-flight data (including the extra stage under the optional feature); the outputs read 0 immediately.
- Columns and templates are fully independent: no cross-cell interaction.

Optional Feature:
- Macro: CORRELATION_LINE_PIPE2_EN.
- Defined:
  - A second register stage follows the multipliers; latency is 2 clocks, to meet timing at high PIXEL_SIZE.
  - Both stages are cleared by RST.
  - I_out_line is delayed identically, so all three outputs stay aligned.
- Undefined: single register stage, latency 1.

Decomposition:
- Shared package correlation_pkg holds:
  - PIXEL_SIZE, LINE_SIZE, NUM_TEMPLATES defaults;
  - typedef pixel_t = logic [PIXEL_SIZE-1:0];
  - typedef prod_t = logic [2*PIXEL_SIZE-1:0].
- Sub-module correlation_cell:
  - one column: inputs I pixel and a T vector [NUM_TEMPLATES];
  - outputs I, I², T·I vector.
- correlation_line_core instantiates LINE_SIZE cells in a generate loop and performs the transpose wiring.

Test Plan:
- Reset: hold RST high with arbitrary inputs, toggle CLK -> all outputs 0; assert RST asynchronously between edges -> outputs go 0 before the next edge.
- Basic: I_in_line[c]=c+1, T_in_line[c][k]=k+1. One edge after release: I_out_line[c]=c+1; I_square_out_line[c]=(c+1)²; T_x_I_out_lines_transpose[k][c]=(k+1)(c+1), e.g. [9][9]=100.
- Extremes: all inputs 255 -> I_square 65025, I_out 255, every T·I 65025. All zero -> all outputs 0.
- Transpose check: only T_in_line[3][7]=200, others 0, I_in_line[3]=2 -> only T_x_I_out_lines_transpose[7][3]=400; all other T·I outputs 0.
- Streaming: new random inputs every cycle, compared against a golden model -> every output matches the inputs of exactly 1 edge earlier (2 with CORRELATION_LINE_PIPE2_EN), with no bubbles.
